mesh_term_in_fifo: RTL and testbench

//  Injection buffer feeding one mesh terminal input. Upstream pushes 40-bit packets; the mesh router pulls them.
//  The router sees pndng/data_out and acknowledges with popin. Packets with an out-of-range destination are rejected.
//  One instance per terminal sits between the agent/driver side and each terminal of the mesh wrapper.

---
 rtl/mesh_term_in_fifo.sv | 115 +++++++++++
 tb/tb_mesh_term_in_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_in_fifo.sv
// Injection FIFO for one mesh terminal input, with destination header filtering.
// Define MESH_TERM_FIFO_STATS_EN to add saturating push/pop/drop counters.
module mesh_term_in_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [pckg_sz-1:0]                data_in,
    output logic                              full,
    output logic                              pndng,
    output logic [pckg_sz-1:0]                data_out,
    input  logic                              popin,
    output logic [$clog2(fifo_depth+1)-1:0]   count,
    output logic                              overflow,
    output logic                              hdr_err
`ifdef MESH_TERM_FIFO_STATS_EN
    ,
    output logic [15:0]                       push_cnt,
    output logic [15:0]                       pop_cnt,
    output logic [15:0]                       drop_cnt
`endif
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth+1);

    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;

    logic [7:0] nxt;
    logic [3:0] row;
    logic [3:0] col;
    logic       hdr_ok;
    logic       pop_eff;
    logic       accept;

    assign nxt = data_in[pckg_sz-1 -: 8];
    assign row = data_in[pckg_sz-9 -: 4];
    assign col = data_in[pckg_sz-13 -: 4];

    // Broadcast packets bypass the destination range check.
    assign hdr_ok = (nxt == 8'hFF) ||
                    ((int'(row) <= ROWS + 1) &&
                     (int'(col) <= COLUMS + 1));

    assign full     = (cnt == CW'(fifo_depth));
    assign pndng    = (cnt != '0);
    assign count    = cnt;
    assign data_out = pndng ? mem[rd_ptr] : '0;

    assign pop_eff = popin & pndng;
    assign accept  = push & hdr_ok & (~full | pop_eff);

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            hdr_err  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({accept, pop_eff})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            hdr_err <= push & ~hdr_ok;
            if (push && hdr_ok && full && !pop_eff) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MESH_TERM_FIFO_STATS_EN
    logic drop;
    assign drop = push & ~accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            push_cnt <= '0;
            pop_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && push_cnt != 16'hFFFF) begin
                push_cnt <= push_cnt + 16'd1;
            end
            if (pop_eff && pop_cnt != 16'hFFFF) begin
                pop_cnt <= pop_cnt + 16'd1;
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mesh_term_in_fifo.sv
// Directed self-checking bench for mesh_term_in_fifo (depth 4, 4x4 mesh).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mesh_term_in_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [39:0] data_in;
    logic        full;
    logic        pndng;
    logic [39:0] data_out;
    logic        popin;
    logic [2:0]  count;
    logic        overflow;
    logic        hdr_err;
`ifdef MESH_TERM_FIFO_STATS_EN
    logic [15:0] push_cnt;
    logic [15:0] pop_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mesh_term_in_fifo #(
        .pckg_sz(40), .fifo_depth(4), .ROWS(4), .COLUMS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .data_in(data_in),
        .full(full),
        .pndng(pndng),
        .data_out(data_out),
        .popin(popin),
        .count(count),
        .overflow(overflow),
        .hdr_err(hdr_err)
`ifdef MESH_TERM_FIFO_STATS_EN
        ,
        .push_cnt(push_cnt),
        .pop_cnt(pop_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [39:0] mk(input logic [7:0] n,
                                       input logic [3:0] r,
                                       input logic [3:0] c,
                                       input logic [23:0] p);
        return {n, r, c, p};
    endfunction

    task automatic cyc(input logic ps, input logic [39:0] d,
                       input logic pp);
        push    = ps;
        data_in = d;
        popin   = pp;
        @(posedge clk);
        #1;
        push  = 1'b0;
        popin = 1'b0;
    endtask

    logic [39:0] pk [5];
    logic [39:0] pj [4];
    logic [39:0] f_pkt;
    logic [39:0] b_pkt;
    logic [39:0] w_pkt;

    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        popin   = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;

        // 1: reset held with push active
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(8'h01, 4'h1, 4'h1, 24'hABCDEF), 1'b0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pndng", 64'(pndng), 64'd0);
        chk("rst_dout", 64'(data_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_hdr", 64'(hdr_err), 64'd0);
        reset = 1'b1;

        // 2: single push latency, then pop and empty pop
        cyc(1'b1, 40'h0112800000, 1'b0);
        chk("t2_pndng", 64'(pndng), 64'd1);
        chk("t2_dout", 64'(data_out), 64'h0112800000);
        chk("t2_count", 64'(count), 64'd1);
        cyc(1'b0, '0, 1'b1);
        chk("t2_pop_cnt", 64'(count), 64'd0);
        chk("t2_pop_dout", 64'(data_out), 64'd0);
        cyc(1'b0, '0, 1'b1);
        chk("t2_emptypop", 64'(count), 64'd0);

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 5; i++) pk[i] = mk(8'h10 + 8'(i), 4'h2, 4'h3, 24'h0A0000 + 24'(i));
        for (int i = 0; i < 4; i++) cyc(1'b1, pk[i], 1'b0);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_cnt4", 64'(count), 64'd4);
        chk("t3_ovf0", 64'(overflow), 64'd0);
        cyc(1'b1, pk[4], 1'b0);
        chk("t3_ovf1", 64'(overflow), 64'd1);
        chk("t3_cnt_e", 64'(count), 64'd4);
        chk("t3_hdr_e", 64'(hdr_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_head%0d", i), 64'(data_out), 64'(pk[i]));
            cyc(1'b0, '0, 1'b1);
        end
        chk("t3_pndng", 64'(pndng), 64'd0);
        chk("t3_full0", 64'(full), 64'd0);

        // 4: push+pop while full
        for (int i = 0; i < 4; i++) pj[i] = mk(8'h20 + 8'(i), 4'h5, 4'h0, 24'h0B0000 + 24'(i));
        f_pkt = mk(8'h2F, 4'h0, 4'h5, 24'hF0F0F0);
        for (int i = 0; i < 4; i++) cyc(1'b1, pj[i], 1'b0);
        cyc(1'b1, f_pkt, 1'b1);
        chk("t4_cnt", 64'(count), 64'd4);
        chk("t4_head", 64'(data_out), 64'(pj[1]));
        chk("t4_ovf", 64'(overflow), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t4_head%0d", i), 64'(data_out), 64'(pj[i]));
            cyc(1'b0, '0, 1'b1);
        end
        chk("t4_headF", 64'(data_out), 64'(f_pkt));
        cyc(1'b0, '0, 1'b1);
        chk("t4_empty", 64'(pndng), 64'd0);

        // 5: header filter, boundaries, broadcast
        cyc(1'b1, mk(8'h01, 4'hF, 4'h1, 24'h1), 1'b0);
        chk("t5_hdr1", 64'(hdr_err), 64'd1);
        chk("t5_cnt0", 64'(count), 64'd0);
        cyc(1'b0, '0, 1'b0);
        chk("t5_hdr_pulse", 64'(hdr_err), 64'd0);
        cyc(1'b1, mk(8'h02, 4'h1, 4'h6, 24'h2), 1'b0);
        chk("t5_col6", 64'(hdr_err), 64'd1);
        chk("t5_col6_cnt", 64'(count), 64'd0);
        b_pkt = mk(8'h03, 4'h5, 4'h5, 24'h3);
        cyc(1'b1, b_pkt, 1'b0);
        chk("t5_edge_hdr", 64'(hdr_err), 64'd0);
        chk("t5_edge_cnt", 64'(count), 64'd1);
        w_pkt = mk(8'hFF, 4'hF, 4'hF, 24'h4);
        cyc(1'b1, w_pkt, 1'b1);
        chk("t5_bc_hdr", 64'(hdr_err), 64'd0);
        chk("t5_bc_cnt1", 64'(count), 64'd1);
        chk("t5_bc_head", 64'(data_out), 64'(w_pkt));
        cyc(1'b0, '0, 1'b1);
        chk("t5_drain", 64'(count), 64'd0);

        // 6: fresh reset, alternating push/pop wraps pointers
        reset = 1'b0;
        cyc(1'b0, '0, 1'b0);
        reset = 1'b1;
        chk("t6_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, mk(8'h40 + 8'(i), 4'h3, 4'h2, 24'hC00000 + 24'(i)), 1'b0);
            chk($sformatf("t6_out%0d", i), 64'(data_out),
                64'(mk(8'h40 + 8'(i), 4'h3, 4'h2, 24'hC00000 + 24'(i))));
            cyc(1'b0, '0, 1'b1);
        end
        chk("t6_cnt", 64'(count), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
`ifdef MESH_TERM_FIFO_STATS_EN
        chk("t6_push_cnt", 64'(push_cnt), 64'd10);
        chk("t6_pop_cnt", 64'(pop_cnt), 64'd10);
        chk("t6_drop0", 64'(drop_cnt), 64'd0);
        cyc(1'b1, mk(8'h01, 4'h7, 4'h0, 24'h0), 1'b0);
        chk("t6_drop1", 64'(drop_cnt), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
